router_fifo_pkt: RTL

//  Parametrised packet-aware FIFO for the router output channels; successor to the fixed 16x8 channel FIFO.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fifo_pkt_cnt.sv | 52 +++++
 rtl/router_fifo_pkt.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router output-channel FIFO family.
package router_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LEN_MSB = 7;
    localparam int DEF_LEN_LSB = 2;
    localparam int DEF_AF_THR  = 14;
    localparam int DEF_AE_THR  = 2;

    // Per-cycle pointer activity, derived from the accepted read/write pair
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Each entry is {tag, data}; the tag sits just above the data word
    function automatic int tag_pos(input int width);
        return width;
    endfunction

endpackage

// File: rtl/router_fifo_pkt_cnt.sv
// Remaining-length tracker for the packet currently being drained from the FIFO.
module router_fifo_pkt_cnt
    import router_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_MSB - DEF_LEN_LSB + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             rd_acc,
    input  logic             tag,
    input  logic [LEN_W-1:0] len_field,
    output logic [LEN_W:0]   pkt_rem,
    output logic             pkt_active
);

    localparam logic [LEN_W:0] REM_ONE  = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] REM_ZERO = {(LEN_W+1){1'b0}};

    logic [LEN_W:0] pkt_rem_q, pkt_rem_d;
    logic           pkt_active_q, pkt_active_d;

    // Header load (payload + parity word), payload decrement saturating at zero
    always_comb begin
        pkt_rem_d = pkt_rem_q;
        if (soft_rst) begin
            pkt_rem_d = REM_ZERO;
        end else if (rd_acc && tag) begin
            pkt_rem_d = {1'b0, len_field} + REM_ONE;
        end else if (rd_acc && (pkt_rem_q != REM_ZERO)) begin
            pkt_rem_d = pkt_rem_q - REM_ONE;
        end else begin
            pkt_rem_d = pkt_rem_q;
        end
        pkt_active_d = (pkt_rem_d != REM_ZERO);
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_rem_q    <= REM_ZERO;
            pkt_active_q <= 1'b0;
        end else begin
            pkt_rem_q    <= pkt_rem_d;
            pkt_active_q <= pkt_active_d;
        end
    end

    assign pkt_rem    = pkt_rem_q;
    assign pkt_active = pkt_active_q;

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware output-channel FIFO: tagged storage, registered read port,
// occupancy thresholds, sticky error flags and a packet-length tracker.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LEN_MSB = DEF_LEN_MSB,
    parameter int LEN_LSB = DEF_LEN_LSB,
    parameter int AF_THR  = DEF_AF_THR,
    parameter int AE_THR  = DEF_AE_THR,
    localparam int AW     = $clog2(DEPTH),
    localparam int LEN_W  = LEN_MSB - LEN_LSB + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             hdr_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      occupancy,
    output logic [LEN_W:0]   pkt_rem,
    output logic             pkt_active,
    output logic             overflow,
    output logic             underflow
);

    localparam int          EW       = WIDTH + 1;
    localparam int          TAG      = tag_pos(WIDTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_THR);
    localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_THR);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             hdr_q, hdr_d, valid_q, valid_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             af_q, af_d, ae_q, ae_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, lfd_q, lfd_d;
    logic             wr_acc_s, rd_acc_s;
    logic [EW-1:0]    head_s;
    fifo_op_e         op_s;

    // Acceptance uses the registered flags, so a same-cycle read never frees room for a write
    assign wr_acc_s = write_enb & ~full_q & ~soft_rst;
    assign rd_acc_s = read_enb & ~empty_q & ~soft_rst;
    assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

    // Classify this cycle's pointer activity
    always_comb begin
        case ({wr_acc_s, rd_acc_s})
            2'b01:   op_s = OP_RD;
            2'b10:   op_s = OP_WR;
            2'b11:   op_s = OP_RW;
            default: op_s = OP_IDLE;
        endcase
    end

    // Next-state for pointers, occupancy, read port and flags
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        data_out_d = data_out_q;
        hdr_d      = hdr_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        lfd_d      = lfd_state;
        if (soft_rst) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            occ_d      = PTR_ZERO;
            data_out_d = {WIDTH{1'b0}};
            hdr_d      = 1'b0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            case (op_s)
                OP_WR: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    occ_d    = occ_q + PTR_ONE;
                end
                OP_RD: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    occ_d    = occ_q - PTR_ONE;
                end
                OP_RW: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
            if (rd_acc_s) begin
                data_out_d = head_s[WIDTH-1:0];
                hdr_d      = head_s[TAG];
            end else begin
                data_out_d = data_out_q;
                hdr_d      = hdr_q;
            end
            valid_d = rd_acc_s;
            ovf_d   = ovf_q | (write_enb & full_q);
            udf_d   = udf_q | (read_enb & empty_q);
        end
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        af_d    = (occ_d >= AF_LVL);
        ae_d    = (occ_d <= AE_LVL);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            occ_q      <= PTR_ZERO;
            data_out_q <= {WIDTH{1'b0}};
            hdr_q      <= 1'b0;
            valid_q    <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            lfd_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            data_out_q <= data_out_d;
            hdr_q      <= hdr_d;
            valid_q    <= valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            lfd_q      <= lfd_d;
        end
    end

    // Storage array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
        end
    end

    router_fifo_pkt_cnt #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .rd_acc     (rd_acc_s),
        .tag        (head_s[TAG]),
        .len_field  (head_s[LEN_MSB:LEN_LSB]),
        .pkt_rem    (pkt_rem),
        .pkt_active (pkt_active)
    );

    assign data_out     = data_out_q;
    assign data_valid   = valid_q;
    assign hdr_out      = hdr_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign occupancy    = occ_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
